// File: rtl/ppu_data_port.sv
// CPU-side PPUADDR/PPUDATA controller: $2006 address latch, $2007 buffered reads,
// post-access increment and palette mirroring toward VRAM and palette RAM.
module ppu_data_port (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [2:0]  cpu_reg,
    input  logic        cpu_wr,
    input  logic        cpu_rd,
    input  logic [7:0]  cpu_din,
    output logic [7:0]  cpu_dout,
    input  logic        inc32,
    output logic        busy,
    output logic [13:0] vram_addr,
    output logic [7:0]  vram_wdata,
    output logic        vram_wren,
    output logic        vram_rden,
    input  logic [7:0]  vram_rdata,
    output logic [4:0]  pal_addr,
    output logic        pal_wren,
    input  logic [7:0]  pal_rdata
);

    typedef enum logic [1:0] {IDLE, WAIT, CAPT} state_t;

    function automatic logic [4:0] mirror(input logic [4:0] a);
        if (a[4] && (a[1:0] == 2'b00)) return {1'b0, a[3:0]};
        return a;
    endfunction

    state_t      state_q, state_d;
    logic [13:0] v_q, v_d;
    logic [5:0]  t_hi_q, t_hi_d;
    logic        w_q, w_d;
    logic [7:0]  buf_q, buf_d;
    logic [7:0]  dout_q, dout_d;
    logic [13:0] vaddr_q, vaddr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        wren_q, wren_d;
    logic        rden_q, rden_d;
    logic        pwren_q, pwren_d;
    logic [4:0]  paddr_q, paddr_d;

    logic        acc_wr, acc_rd, is_pal;
    logic [13:0] v_inc;

    always_comb begin
        state_d = state_q;
        v_d     = v_q;
        t_hi_d  = t_hi_q;
        w_d     = w_q;
        buf_d   = buf_q;
        dout_d  = dout_q;
        vaddr_d = vaddr_q;
        wdata_d = wdata_q;
        paddr_d = paddr_q;
        wren_d  = 1'b0;
        rden_d  = 1'b0;
        pwren_d = 1'b0;

        // Accesses arriving while a read is in flight are dropped; write beats read.
        acc_wr = cpu_wr && (state_q == IDLE);
        acc_rd = cpu_rd && !cpu_wr && (state_q == IDLE);
        is_pal = (v_q >= 14'h3F00);
        v_inc  = v_q + (inc32 ? 14'd32 : 14'd1);

        case (state_q)
            IDLE: begin
                if (acc_wr) begin
                    if (cpu_reg == 3'd6) begin
                        if (!w_q) begin
                            t_hi_d = cpu_din[5:0];
                            w_d    = 1'b1;
                        end else begin
                            v_d = {t_hi_q, cpu_din};
                            w_d = 1'b0;
                        end
                    end else if (cpu_reg == 3'd7) begin
                        wdata_d = cpu_din;
                        v_d     = v_inc;
                        if (!is_pal) begin
                            vaddr_d = v_q;
                            wren_d  = 1'b1;
                        end else begin
                            paddr_d = mirror(v_q[4:0]);
                            pwren_d = 1'b1;
                        end
                    end
                end else if (acc_rd) begin
                    if (cpu_reg == 3'd2) begin
                        w_d = 1'b0;
                    end else if (cpu_reg == 3'd7) begin
                        dout_d  = is_pal ? pal_rdata : buf_q;
                        // Palette reads still refill the buffer from the nametable underneath.
                        vaddr_d = v_q & 14'h2FFF;
                        rden_d  = 1'b1;
                        v_d     = v_inc;
                        state_d = WAIT;
                    end
                end
            end
            WAIT: state_d = CAPT;
            CAPT: begin
                buf_d   = vram_rdata;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            v_q     <= '0;
            t_hi_q  <= '0;
            w_q     <= 1'b0;
            buf_q   <= '0;
            dout_q  <= '0;
            vaddr_q <= '0;
            wdata_q <= '0;
            wren_q  <= 1'b0;
            rden_q  <= 1'b0;
            pwren_q <= 1'b0;
            paddr_q <= '0;
        end else begin
            state_q <= state_d;
            v_q     <= v_d;
            t_hi_q  <= t_hi_d;
            w_q     <= w_d;
            buf_q   <= buf_d;
            dout_q  <= dout_d;
            vaddr_q <= vaddr_d;
            wdata_q <= wdata_d;
            wren_q  <= wren_d;
            rden_q  <= rden_d;
            pwren_q <= pwren_d;
            paddr_q <= paddr_d;
        end
    end

    // Hold the write index during the strobe; otherwise track v for combinational reads.
    assign pal_addr   = pwren_q ? paddr_q : mirror(v_q[4:0]);
    assign cpu_dout   = dout_q;
    assign busy       = (state_q != IDLE);
    assign vram_addr  = vaddr_q;
    assign vram_wdata = wdata_q;
    assign vram_wren  = wren_q;
    assign vram_rden  = rden_q;
    assign pal_wren   = pwren_q;

endmodule

// File: tb/tb_ppu_data_port.sv
// Directed bench for ppu_data_port with behavioural VRAM/palette models and a read scoreboard.
module tb_ppu_data_port;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  cpu_reg = '0;
    logic        cpu_wr = 1'b0;
    logic        cpu_rd = 1'b0;
    logic [7:0]  cpu_din = '0;
    logic [7:0]  cpu_dout;
    logic        inc32 = 1'b0;
    logic        busy;
    logic [13:0] vram_addr;
    logic [7:0]  vram_wdata;
    logic        vram_wren;
    logic        vram_rden;
    logic [7:0]  vram_rdata = '0;
    logic [4:0]  pal_addr;
    logic        pal_wren;
    logic [7:0]  pal_rdata;

    int checks = 0;
    int failures = 0;

    logic [7:0]  vmem [0:16383];
    logic [7:0]  pmem [0:31];
    logic [7:0]  exp_q [$];
    logic [7:0]  sh_v [int];
    logic [7:0]  sh_p [int];
    logic [13:0] mv = '0;
    logic [7:0]  mbuf = '0;

    ppu_data_port dut (
        .clk(clk), .reset_n(reset_n), .cpu_reg(cpu_reg), .cpu_wr(cpu_wr),
        .cpu_rd(cpu_rd), .cpu_din(cpu_din), .cpu_dout(cpu_dout), .inc32(inc32),
        .busy(busy), .vram_addr(vram_addr), .vram_wdata(vram_wdata),
        .vram_wren(vram_wren), .vram_rden(vram_rden), .vram_rdata(vram_rdata),
        .pal_addr(pal_addr), .pal_wren(pal_wren), .pal_rdata(pal_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (vram_rden) vram_rdata <= vmem[vram_addr];
        if (vram_wren) vmem[vram_addr] <= vram_wdata;
        if (pal_wren)  pmem[pal_addr] <= vram_wdata;
    end
    assign pal_rdata = pmem[pal_addr];

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [4:0] mir(input logic [4:0] a);
        return (a[4] && a[1:0] == 2'b00) ? {1'b0, a[3:0]} : a;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_wr(input logic [2:0] r, input logic [7:0] d);
        cpu_reg = r; cpu_din = d; cpu_wr = 1'b1;
        tick();
        cpu_wr = 1'b0;
    endtask

    task automatic do_rd(input logic [2:0] r);
        cpu_reg = r; cpu_rd = 1'b1;
        tick();
        cpu_rd = 1'b0;
    endtask

    task automatic setv(input logic [13:0] a);
        do_wr(3'd6, {2'b00, a[13:8]});
        do_wr(3'd6, a[7:0]);
        mv = a;
    endtask

    task automatic w7(input logic [7:0] d);
        do_wr(3'd7, d);
        chk("wdata", vram_wdata, d);
        if (mv < 14'h3F00) begin
            chk("wren", vram_wren, 1);
            chk("waddr", vram_addr, mv);
            chk("pwren_lo", pal_wren, 0);
            sh_v[int'(mv)] = d;
        end else begin
            chk("pwren", pal_wren, 1);
            chk("paddr", pal_addr, mir(mv[4:0]));
            chk("wren_lo", vram_wren, 0);
            sh_p[int'(mir(mv[4:0]))] = d;
        end
        mv = mv + (inc32 ? 14'd32 : 14'd1);
    endtask

    // Issues the strobe and checks through E0; returns at E0+1.
    task automatic r7_start();
        logic [13:0] na;
        na = mv & 14'h2FFF;
        if (mv >= 14'h3F00) exp_q.push_back(sh_p[int'(mir(mv[4:0]))]);
        else                exp_q.push_back(mbuf);
        do_rd(3'd7);
        if (exp_q.size() == 0) chk("sb_empty", 1, 0);
        else chk("dout", cpu_dout, exp_q.pop_front());
        chk("rden", vram_rden, 1);
        chk("raddr", vram_addr, na);
        chk("busy_e0", busy, 1);
        mbuf = sh_v.exists(int'(na)) ? sh_v[int'(na)] : 8'h00;
        mv = mv + (inc32 ? 14'd32 : 14'd1);
    endtask

    task automatic r7();
        r7_start();
        tick();
        chk("busy_e1", busy, 1);
        chk("rden_e1", vram_rden, 0);
        tick();
        chk("busy_e2", busy, 0);
    endtask

    initial begin
        #12;
        chk("rst_dout", cpu_dout, 0);
        chk("rst_busy", busy, 0);
        chk("rst_vaddr", vram_addr, 0);
        chk("rst_wdata", vram_wdata, 0);
        chk("rst_wren", vram_wren, 0);
        chk("rst_rden", vram_rden, 0);
        chk("rst_paddr", pal_addr, 0);
        chk("rst_pwren", pal_wren, 0);
        @(negedge clk); reset_n = 1'b1;
        tick();

        // Address latch and write with increment
        setv(14'h2108);
        w7(8'hAB);
        tick();
        chk("wren_one_cycle", vram_wren, 0);
        w7(8'hCD);
        chk("next_addr", vram_addr, 14'h2109);

        // Preload VRAM and palette through the port
        setv(14'h2000); w7(8'h11); w7(8'h22);
        setv(14'h2F01); w7(8'h5C);
        setv(14'h3F01); w7(8'h2A);

        // Buffered reads, three cycles apart
        setv(14'h2000);
        r7(); r7(); r7();

        // Increment by 32 across a nametable boundary
        inc32 = 1'b1;
        setv(14'h23E0); w7(8'h01); w7(8'h02);
        chk("inc32_addr", vram_addr, 14'h2400);
        inc32 = 1'b0;

        // VRAM to palette crossing, then 14-bit wrap
        setv(14'h3EFF); w7(8'h03); w7(8'h0F);
        chk("pal_3f00", pal_addr, 5'h00);
        setv(14'h3FFF); w7(8'h04); w7(8'h05);
        chk("wrap_addr", vram_addr, 14'h0000);

        // Palette mirror write, palette read with nametable refill
        setv(14'h3F10); w7(8'h0F);
        chk("mirror_3f10", pal_addr, 5'h00);
        setv(14'h3F01); r7();
        setv(14'h2000); r7();

        // $2002 read clears the write toggle
        do_wr(3'd6, 8'h3F);
        do_rd(3'd2);
        do_wr(3'd6, 8'h21);
        do_wr(3'd6, 8'h00);
        mv = 14'h2100;
        w7(8'h06);
        chk("toggle_addr", vram_addr, 14'h2100);

        // Write during a read is dropped
        setv(14'h2000);
        r7_start();
        cpu_reg = 3'd7; cpu_din = 8'hEE; cpu_wr = 1'b1;
        tick();
        cpu_wr = 1'b0;
        chk("drop_wren", vram_wren, 0);
        chk("drop_pwren", pal_wren, 0);
        chk("drop_busy", busy, 1);
        tick();
        chk("drop_busy_e2", busy, 0);
        w7(8'h07);
        chk("drop_v", vram_addr, 14'h2001);

        // Reset during a read
        setv(14'h2000);
        r7_start();
        tick();
        reset_n = 1'b0;
        #1;
        chk("rr_dout", cpu_dout, 0);
        chk("rr_busy", busy, 0);
        chk("rr_vaddr", vram_addr, 0);
        chk("rr_wdata", vram_wdata, 0);
        chk("rr_rden", vram_rden, 0);
        chk("rr_wren", vram_wren, 0);
        chk("rr_pwren", pal_wren, 0);
        chk("rr_paddr", pal_addr, 0);
        @(negedge clk); reset_n = 1'b1;
        mv = '0; mbuf = 8'h00;
        tick();
        setv(14'h2000);
        r7();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
